// File: rtl/fifo9_rr_mux.sv
// fifo9_rr_mux: frame-atomic round-robin merge of N 9-bit GMII receive FIFOs
// into one output FIFO, truncating oversize frames and appending GapOut gap words per frame.
module fifo9_rr_mux #(
  parameter int unsigned N      = 4,
  parameter int unsigned GapOut = 2,
  parameter int unsigned MaxLen = 1522
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [9*N-1:0]  in_dout,
  input  logic [N-1:0]    in_empty,
  output logic [N-1:0]    in_rd_en,
  output logic [8:0]      out_din,
  output logic            out_wr_en,
  input  logic            out_afull,
  output logic [16*N-1:0] frame_cnt,
  output logic [15:0]     trunc_cnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = 12;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_XFER,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] sel, sel_nxt;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [LW-1:0] len, len_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [8:0]    din_nxt;
  logic          wr_nxt;
  logic          fc_inc;
  logic          tr_inc;
  logic [15:0]   fcnt [N];

  logic [8:0]    head [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  stray;
  logic [8:0]    sel_head;
  logic          sel_avail;
  logic          arb_found;
  logic [PW-1:0] arb_sel;
  logic [PW:0]   scan;

  // Per-port head word classification: data heads compete, gap heads are discarded in ARB
  always_comb begin
    for (int unsigned p = 0; p < N; p++) begin
      head[p]  = in_dout[9*p +: 9];
      elig[p]  = !in_empty[p] && head[p][8];
      stray[p] = !in_empty[p] && !head[p][8];
    end
  end

  // Round-robin pick: first eligible port at or after rr_ptr, wrapping mod N
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(N)) begin
        scan = scan - (PW+1)'(N);
      end
      if (!arb_found && elig[scan[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = scan[PW-1:0];
      end
    end
  end

  // Next-state, pop strobes and registered-output next values
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    len_nxt   = len;
    gcnt_nxt  = gcnt;
    din_nxt   = 9'h000;
    wr_nxt    = 1'b0;
    in_rd_en  = '0;
    fc_inc    = 1'b0;
    tr_inc    = 1'b0;
    sel_head  = head[sel];
    sel_avail = !in_empty[sel];

    unique case (state)
      ST_ARB: begin
        in_rd_en = stray;
        if (arb_found) begin
          state_nxt = ST_XFER;
          sel_nxt   = arb_sel;
          len_nxt   = '0;
        end
      end

      ST_XFER: begin
        if (sel_avail && !out_afull) begin
          in_rd_en[sel] = 1'b1;
          wr_nxt        = 1'b1;
          if (!sel_head[8]) begin
            fc_inc    = 1'b1;
            state_nxt = ST_GAP;
            gcnt_nxt  = GW'(GapOut - 1);
          end else if (len == LW'(MaxLen)) begin
            tr_inc    = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            din_nxt = sel_head;
            len_nxt = len + LW'(1);
          end
        end
      end

      // Discard the oversize remainder without writing and regardless of backpressure
      ST_DRAIN: begin
        if (sel_avail) begin
          in_rd_en[sel] = 1'b1;
          if (!sel_head[8]) begin
            state_nxt = ST_GAP;
            gcnt_nxt  = GW'(GapOut - 1);
          end
        end
      end

      ST_GAP: begin
        if (gcnt == '0) begin
          state_nxt = ST_ARB;
          rr_nxt    = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
        end else if (!out_afull) begin
          wr_nxt   = 1'b1;
          gcnt_nxt = gcnt - GW'(1);
        end
      end

      default: begin
        state_nxt = ST_ARB;
      end
    endcase
  end

  // State, output and counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_ARB;
      sel       <= '0;
      rr_ptr    <= '0;
      len       <= '0;
      gcnt      <= '0;
      out_din   <= 9'h000;
      out_wr_en <= 1'b0;
      trunc_cnt <= '0;
      for (int unsigned p = 0; p < N; p++) begin
        fcnt[p] <= '0;
      end
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      rr_ptr    <= rr_nxt;
      len       <= len_nxt;
      gcnt      <= gcnt_nxt;
      out_din   <= din_nxt;
      out_wr_en <= wr_nxt;
      if (tr_inc) begin
        trunc_cnt <= trunc_cnt + 16'd1;
      end
      for (int unsigned p = 0; p < N; p++) begin
        if (fc_inc && (sel == PW'(p))) begin
          fcnt[p] <= fcnt[p] + 16'd1;
        end
      end
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_pack
    assign frame_cnt[16*p +: 16] = fcnt[p];
  end

endmodule

// File: tb/tb_fifo9_rr_mux.sv
// tb_fifo9_rr_mux: bench-side port FIFO model feeds fifo9_rr_mux; every output write
// is popped from an expected-word queue filled when frames are loaded.
module tb_fifo9_rr_mux;

  localparam int unsigned N      = 4;
  localparam int unsigned GAPO   = 2;
  localparam int unsigned MAXL_M = 1522;
  localparam int unsigned MAXL_T = 16;
  localparam int          BUDGET = 5000;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic            use_t;
  logic            out_afull;
  logic [9*N-1:0]  tb_dout;
  logic [N-1:0]    tb_empty;
  logic [N-1:0]    empty_m, empty_t, rd_m, rd_t, rd_sel;
  logic [8:0]      din_m, din_t;
  logic            wr_m, wr_t;
  logic [16*N-1:0] fc_m, fc_t;
  logic [15:0]     tc_m, tc_t;

  logic [8:0]      pq [N][$];
  logic [8:0]      exp_q [$];
  int unsigned     exp_fc [N];
  logic [N-1:0]    rd_q, emp_q;
  logic            afull_q;
  int              checks = 0;
  int              failures = 0;

  // Only one DUT sees the port model at a time; the other sees empty ports
  assign empty_m = use_t ? '1 : tb_empty;
  assign empty_t = use_t ? tb_empty : '1;
  assign rd_sel  = use_t ? rd_t : rd_m;

  fifo9_rr_mux #(.N(N), .GapOut(GAPO), .MaxLen(MAXL_M)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_dout   (tb_dout),
    .in_empty  (empty_m),
    .in_rd_en  (rd_m),
    .out_din   (din_m),
    .out_wr_en (wr_m),
    .out_afull (out_afull),
    .frame_cnt (fc_m),
    .trunc_cnt (tc_m)
  );

  fifo9_rr_mux #(.N(N), .GapOut(GAPO), .MaxLen(MAXL_T)) dut_t (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_dout   (tb_dout),
    .in_empty  (empty_t),
    .in_rd_en  (rd_t),
    .out_din   (din_t),
    .out_wr_en (wr_t),
    .out_afull (out_afull),
    .frame_cnt (fc_t),
    .trunc_cnt (tc_t)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    rd_q    <= rd_sel;
    emp_q   <= tb_empty;
    afull_q <= out_afull;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1, "bench timeout");
  end

  // Port FIFO model and output scoreboard, evaluated on the falling edge
  task automatic run_io();
    logic [8:0] e;
    logic [8:0] got;
    forever begin
      @(negedge sys_clk);
      for (int p = 0; p < N; p++) begin
        if (rd_q[p]) begin
          checks++;
          if (emp_q[p]) begin
            failures++;
            $display("FAIL pop_empty port=%0d rd_en=1 required=0", p);
          end else if (pq[p].size() > 0) begin
            void'(pq[p].pop_front());
          end
        end
      end
      if (use_t ? wr_t : wr_m) begin
        got = use_t ? din_t : din_m;
        checks++;
        if (afull_q) begin
          failures++;
          $display("FAIL write_while_afull got_wr=1 required_wr=0");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got=%h required=no_write", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL out_din got=%h required=%h", got, e);
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        tb_empty[p]        = (pq[p].size() == 0);
        tb_dout[9*p +: 9]  = (pq[p].size() > 0) ? pq[p][0] : 9'h000;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_model();
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      exp_fc[p] = 0;
    end
    exp_q.delete();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    out_afull = 1'b0;
    clear_model();
    step(2);
    sys_rst_n = 1'b1;
    step(1);
  endtask

  // Load one frame: len data words then one input gap word; expected output is
  // min(len,maxl) data words followed by GAPO zero words
  task automatic push_frame(input int p, input int len, input int maxl);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {1'b1, 8'($urandom)};
      pq[p].push_back(w);
      if (i < maxl) exp_q.push_back(w);
    end
    pq[p].push_back(9'h000);
    repeat (GAPO) exp_q.push_back(9'h000);
    if (len <= maxl && !use_t) exp_fc[p]++;
  endtask

  function automatic bit model_idle();
    bit idle;
    idle = (exp_q.size() == 0);
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() != 0) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (!model_idle() && cyc < BUDGET) begin
      step(1);
      cyc++;
    end
    checks++;
    if (cyc >= BUDGET) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
    end
    step(4);
  endtask

  task automatic check_counts(input string name);
    for (int p = 0; p < N; p++) begin
      checks++;
      if (fc_m[16*p +: 16] !== 16'(exp_fc[p])) begin
        failures++;
        $display("FAIL %s_frame_cnt%0d got=%0d required=%0d", name, p, fc_m[16*p +: 16], exp_fc[p]);
      end
    end
    checks++;
    if (tc_m !== 16'd0) begin
      failures++;
      $display("FAIL %s_trunc_cnt got=%0d required=0", name, tc_m);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (wr_m !== 1'b0 || din_m !== 9'h000 || rd_m !== '0) begin
      failures++;
      $display("FAIL reset_outputs got_wr=%b got_din=%h got_rd=%b required=0/000/0", wr_m, din_m, rd_m);
    end
    check_counts("reset_init");
    push_frame(1, 8, MAXL_M);
    wait_drain("reset_pre");
    check_counts("reset_pre");
    // Abort a port-3 frame mid-transfer
    push_frame(3, 50, MAXL_M);
    step(15);
    sys_rst_n = 1'b0;
    clear_model();
    step(1);
    checks++;
    if (wr_m !== 1'b0 || din_m !== 9'h000) begin
      failures++;
      $display("FAIL reset_mid_out got_wr=%b got_din=%h required=0/000", wr_m, din_m);
    end
    checks++;
    if (fc_m !== '0 || tc_m !== '0) begin
      failures++;
      $display("FAIL reset_mid_counters got_fc=%h got_tc=%h required=0", fc_m, tc_m);
    end
    step(1);
    checks++;
    if (rd_m !== '0) begin
      failures++;
      $display("FAIL reset_mid_rd_en got=%b required=0", rd_m);
    end
    sys_rst_n = 1'b1;
    step(1);
    // Pointer is back at 0, so port 0 goes before port 3
    push_frame(0, 5, MAXL_M);
    push_frame(3, 5, MAXL_M);
    wait_drain("reset_post");
    check_counts("reset_post");
  endtask

  task automatic test_single_frame();
    push_frame(2, 64, MAXL_M);
    wait_drain("single");
    check_counts("single");
    // Port 2 served last, so port 3 now outranks port 0
    push_frame(3, 6, MAXL_M);
    push_frame(0, 6, MAXL_M);
    wait_drain("single_rr");
    check_counts("single_rr");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      push_frame(0, 60, MAXL_M);
      push_frame(1, 60, MAXL_M);
      push_frame(3, 60, MAXL_M);
    end
    wait_drain("rr");
    check_counts("rr");
  endtask

  task automatic test_backpressure();
    int cyc;
    push_frame(2, 100, MAXL_M);
    cyc = 0;
    while (!model_idle() && cyc < BUDGET) begin
      if (cyc % 3 == 0) out_afull = ~out_afull;
      step(1);
      cyc++;
    end
    out_afull = 1'b0;
    wait_drain("bp");
    check_counts("bp");
  endtask

  task automatic test_truncation();
    use_t = 1'b1;
    step(1);
    push_frame(1, 40, MAXL_T);
    wait_drain("trunc");
    checks++;
    if (tc_t !== 16'd1) begin
      failures++;
      $display("FAIL trunc_cnt got=%0d required=1", tc_t);
    end
    checks++;
    if (fc_t[16 +: 16] !== 16'd0) begin
      failures++;
      $display("FAIL trunc_frame_cnt1 got=%0d required=0", fc_t[16 +: 16]);
    end
    use_t = 1'b0;
    step(1);
    check_counts("trunc_main");
  endtask

  task automatic test_stray_underflow();
    logic [8:0] w;
    repeat (3) pq[0].push_back(9'h000);
    for (int i = 0; i < 10; i++) begin
      w = {1'b1, 8'($urandom)};
      pq[0].push_back(w);
      exp_q.push_back(w);
    end
    wait_drain("stray_a");
    step(16);
    for (int i = 0; i < 10; i++) begin
      w = {1'b1, 8'($urandom)};
      pq[0].push_back(w);
      exp_q.push_back(w);
    end
    pq[0].push_back(9'h000);
    repeat (GAPO) exp_q.push_back(9'h000);
    exp_fc[0]++;
    wait_drain("stray_b");
    check_counts("stray");
  endtask

  initial begin
    sys_rst_n = 1'b0;
    use_t     = 1'b0;
    out_afull = 1'b0;
    tb_empty  = '1;
    tb_dout   = '0;
    fork
      run_io();
    join_none
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_stray_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
